// File: rtl/types.sv
// Shared types and constants for the ray unit model.
// Job record, vector type, latency modes and the LFSR step.
`ifndef DISPLAY_WIDTH
`define DISPLAY_WIDTH 320
`endif
`ifndef DISPLAY_HEIGHT
`define DISPLAY_HEIGHT 240
`endif
`ifndef H_BITS
`define H_BITS 9
`endif
`ifndef V_BITS
`define V_BITS 8
`endif

package ray_unit_model_pkg;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic signed [15:0] z;
    } vec3_t;

    typedef struct packed {
        logic [`H_BITS-1:0] hcount;
        logic [`V_BITS-1:0] vcount;
        logic [3:0]         color;
    } job_t;

    typedef enum logic {
        LAT_MODE_FIXED = 1'b0,
        LAT_MODE_LFSR  = 1'b1
    } lat_mode_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ LFSR_TAPS;
        return n;
    endfunction

endpackage

// File: rtl/ray_job_fifo.sv
// Synchronous job queue with occupancy count.
// Push and pop may occur on the same edge.
module ray_job_fifo
    import ray_unit_model_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     push,
    input  logic                     pop,
    input  job_t                     din,
    output job_t                     dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    job_t            mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ray_unit_model.sv
// Behavioural stand-in for a ray core: queues jobs, holds each for a
// fixed or pseudo-random latency, then retires them in order.
`ifndef DISPLAY_WIDTH
`define DISPLAY_WIDTH 320
`endif
`ifndef DISPLAY_HEIGHT
`define DISPLAY_HEIGHT 240
`endif
`ifndef H_BITS
`define H_BITS 9
`endif
`ifndef V_BITS
`define V_BITS 8
`endif

module ray_unit_model
    import ray_unit_model_pkg::*;
#(
    parameter int DISPLAY_WIDTH  = `DISPLAY_WIDTH,
    parameter int DISPLAY_HEIGHT = `DISPLAY_HEIGHT,
    parameter int H_BITS         = `H_BITS,
    parameter int V_BITS         = `V_BITS,
    parameter int CORE_IDX       = 0,
    parameter int DEPTH          = 4,
    parameter int LAT_MODE       = 0,
    parameter int LAT_FIXED      = 8,
    parameter int LAT_MIN        = 1,
    parameter int LAT_SPAN_LOG2  = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  vec3_t             ray_origin_in,
    input  vec3_t             ray_direction_in,
    input  logic [2:0]        fractal_sel_in,
    input  logic [H_BITS-1:0] hcount_in,
    input  logic [V_BITS-1:0] vcount_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic [H_BITS-1:0] hcount_out,
    output logic [V_BITS-1:0] vcount_out,
    output logic [3:0]        color_out,
    output logic              valid_out,
    output logic              busy_out
);

    localparam bit IS_LFSR = (LAT_MODE == int'(LAT_MODE_LFSR));
    localparam int LAT_MAX = IS_LFSR ? LAT_MIN + (1 << LAT_SPAN_LOG2) - 1
                                     : LAT_FIXED;
    localparam int CW = $clog2(LAT_MAX + 1);
    localparam int QW = $clog2(DEPTH) + 1;

    localparam logic [15:0] SEED_RAW = LFSR_SEED ^ 16'(CORE_IDX);
    localparam logic [15:0] SEED = (SEED_RAW == 16'h0) ? 16'h0001 : SEED_RAW;

    job_t            job_in;
    job_t            head;
    job_t            cur;
    logic            active;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   lat;
    logic [15:0]     lfsr;
    logic            full;
    logic            empty;
    logic [QW-1:0]   qcount;
    logic            accept;
    logic            retire;
    logic            push;
    logic            pop;
    logic            unused_ok;

    assign job_in.hcount = $bits(job_in.hcount)'(hcount_in);
    assign job_in.vcount = $bits(job_in.vcount)'(vcount_in);
    assign job_in.color  = hcount_in[3:0] ^ vcount_in[3:0]
                         ^ {1'b0, fractal_sel_in};

    assign ready_out = !full;
    assign accept    = valid_in && ready_out;
    assign retire    = active && (cnt == CW'(1));
    assign pop       = retire && !empty;
    // an accept bypasses the queue only when the slot is free this edge
    assign push      = accept && active && !(retire && empty);
    assign busy_out  = active || (qcount != '0);

    assign lat = IS_LFSR ? CW'(LAT_MIN) + CW'(lfsr[LAT_SPAN_LOG2-1:0])
                         : CW'(LAT_FIXED);

    assign unused_ok = ^{ray_origin_in, ray_direction_in,
                         16'(DISPLAY_WIDTH), 16'(DISPLAY_HEIGHT)};

    ray_job_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (push),
        .pop    (pop),
        .din    (job_in),
        .dout   (head),
        .full   (full),
        .empty  (empty),
        .count  (qcount)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            active     <= 1'b0;
            cnt        <= '0;
            cur        <= '0;
            lfsr       <= SEED;
            valid_out  <= 1'b0;
            hcount_out <= '0;
            vcount_out <= '0;
            color_out  <= '0;
        end else begin
            lfsr      <= lfsr_next(lfsr);
            valid_out <= retire;
            if (retire) begin
                hcount_out <= H_BITS'(cur.hcount);
                vcount_out <= V_BITS'(cur.vcount);
                color_out  <= cur.color;
            end
            if (retire && !empty) begin
                cur <= head;
                cnt <= lat;
            end else if (accept && (!active || retire)) begin
                cur    <= job_in;
                cnt    <= lat;
                active <= 1'b1;
            end else if (retire) begin
                active <= 1'b0;
            end else if (active) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ray_unit_model.sv
// Scoreboard bench for ray_unit_model across fixed and LFSR latency builds.
module tb_ray_unit_model;
    import ray_unit_model_pkg::*;

    localparam int HB = 9;
    localparam int VB = 8;
    localparam int N  = 5;
    localparam int MODE [N] = '{0, 0, 0, 1, 1};
    localparam int LFIX [N] = '{8, 1, 20, 8, 8};
    localparam int CORE [N] = '{0, 0, 0, 0, 1};

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    always #5 clk_in = ~clk_in;

    vec3_t          org;
    vec3_t          dir;
    logic [2:0]     sel;
    logic [HB-1:0]  hin;
    logic [VB-1:0]  vin_c;
    logic           vld;

    logic           rdy  [N];
    logic           vout [N];
    logic           bsy  [N];
    logic [HB-1:0]  ho   [N];
    logic [VB-1:0]  vo   [N];
    logic [3:0]     co   [N];

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [HB-1:0] h;
        logic [VB-1:0] v;
        logic [3:0]    c;
        int            t;
    } exp_t;

    exp_t sb[$];
    int   lat_seq [2][200];

    for (genvar g = 0; g < N; g++) begin : g_dut
        ray_unit_model #(
            .H_BITS        (HB),
            .V_BITS        (VB),
            .CORE_IDX      (CORE[g]),
            .DEPTH         (4),
            .LAT_MODE      (MODE[g]),
            .LAT_FIXED     (LFIX[g]),
            .LAT_MIN       (1),
            .LAT_SPAN_LOG2 (4)
        ) u_dut (
            .clk_in           (clk_in),
            .rst_in           (rst_in),
            .ray_origin_in    (org),
            .ray_direction_in (dir),
            .fractal_sel_in   (sel),
            .hcount_in        (hin),
            .vcount_in        (vin_c),
            .valid_in         (vld),
            .ready_out        (rdy[g]),
            .hcount_out       (ho[g]),
            .vcount_out       (vo[g]),
            .color_out        (co[g]),
            .valid_out        (vout[g]),
            .busy_out         (bsy[g])
        );
    end

    function automatic logic [3:0] col(logic [HB-1:0] h, logic [VB-1:0] v,
                                       logic [2:0] s);
        return h[3:0] ^ v[3:0] ^ {1'b0, s};
    endfunction

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        vld    = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < N; i++) begin
            tests++;
            if ({rdy[i], vout[i], bsy[i]} !== 3'b100 || ho[i] !== '0
                || vo[i] !== '0 || co[i] !== '0) begin
                fails++;
                $display("FAIL reset[%0d]: rdy=%b vout=%b busy=%b h=%0d v=%0d c=%h, want 1 0 0 0 0 0",
                         i, rdy[i], vout[i], bsy[i], ho[i], vo[i], co[i]);
            end
        end
    endtask

    task automatic test_single();
        int   pulses = 0;
        exp_t e;
        do_reset();
        hin = 5; vin_c = 3; sel = 2; vld = 1'b1;
        sb.push_back('{h: 9'd5, v: 8'd3, c: 4'h4, t: 9});
        tests++;
        if (rdy[0] !== 1'b1) begin
            fails++;
            $display("FAIL single_ready: got %b want 1", rdy[0]);
        end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk_in);
            vld = 1'b0;
            if (c == 1) begin
                tests++;
                if (bsy[0] !== 1'b1) begin
                    fails++;
                    $display("FAIL single_busy: got %b want 1", bsy[0]);
                end
            end
            if (vout[0]) begin
                pulses++;
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL single_extra: pulse at cycle %0d, none expected", c);
                end else begin
                    e = sb.pop_front();
                    if ({ho[0], vo[0], co[0]} !== {e.h, e.v, e.c} || c != e.t) begin
                        fails++;
                        $display("FAIL single_pulse: got h=%0d v=%0d c=%h @%0d want h=%0d v=%0d c=%h @%0d",
                                 ho[0], vo[0], co[0], c, e.h, e.v, e.c, e.t);
                    end
                end
            end
        end
        tests++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL single_count: got %0d pulses want 1", pulses);
        end
        tests++;
        if (ho[0] !== 9'd5 || vo[0] !== 8'd3 || co[0] !== 4'h4) begin
            fails++;
            $display("FAIL single_hold: got h=%0d v=%0d c=%h want 5 3 4",
                     ho[0], vo[0], co[0]);
        end
    endtask

    task automatic test_back_to_back();
        int   got = 0;
        exp_t e;
        do_reset();
        hin = 1; vin_c = 2; sel = 3; vld = 1'b1;
        sb.push_back('{h: 9'd1, v: 8'd2, c: col(9'd1, 8'd2, 3'd3), t: 9});
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk_in);
            if (vout[0]) begin
                got++;
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL b2b_extra: pulse at cycle %0d, none expected", c);
                end else begin
                    e = sb.pop_front();
                    if ({ho[0], vo[0], co[0]} !== {e.h, e.v, e.c} || c != e.t) begin
                        fails++;
                        $display("FAIL b2b_pulse: got h=%0d v=%0d c=%h @%0d want h=%0d v=%0d c=%h @%0d",
                                 ho[0], vo[0], co[0], c, e.h, e.v, e.c, e.t);
                    end
                end
            end
            if (c == 8) begin
                hin = 7; vin_c = 9; sel = 1; vld = 1'b1;
                tests++;
                if (rdy[0] !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_ready: got %b want 1", rdy[0]);
                end
                sb.push_back('{h: 9'd7, v: 8'd9, c: col(9'd7, 8'd9, 3'd1), t: 17});
            end else begin
                vld = 1'b0;
            end
        end
        tests++;
        if (got != 2 || sb.size() != 0) begin
            fails++;
            $display("FAIL b2b_count: got %0d pulses want 2", got);
        end
    endtask

    task automatic test_stream();
        int   got = 0;
        exp_t e;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk_in);
            if (vout[1]) begin
                got++;
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL stream_extra: pulse at cycle %0d, none expected", c);
                end else begin
                    e = sb.pop_front();
                    if ({ho[1], vo[1], co[1]} !== {e.h, e.v, e.c} || c != e.t) begin
                        fails++;
                        $display("FAIL stream_pulse: got h=%0d v=%0d c=%h @%0d want h=%0d v=%0d c=%h @%0d",
                                 ho[1], vo[1], co[1], c, e.h, e.v, e.c, e.t);
                    end
                end
            end
            if (c < 10) begin
                hin = HB'(c * 3); vin_c = VB'(c * 5 + 1); sel = 3'(c);
                vld = 1'b1;
                tests++;
                if (rdy[1] !== 1'b1) begin
                    fails++;
                    $display("FAIL stream_ready: got %b want 1 at cycle %0d", rdy[1], c);
                end
                sb.push_back('{h: hin, v: vin_c, c: col(hin, vin_c, sel), t: c + 2});
            end else begin
                vld = 1'b0;
            end
        end
        tests++;
        if (got != 10 || sb.size() != 0) begin
            fails++;
            $display("FAIL stream_count: got %0d pulses want 10", got);
        end
    endtask

    task automatic test_full();
        int   got = 0;
        logic exp_rdy;
        exp_t e;
        do_reset();
        for (int c = 0; c < 112; c++) begin
            if (c > 0) @(negedge clk_in);
            if (vout[2]) begin
                got++;
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL full_extra: pulse at cycle %0d, none expected", c);
                end else begin
                    e = sb.pop_front();
                    if ({ho[2], vo[2], co[2]} !== {e.h, e.v, e.c} || c != e.t) begin
                        fails++;
                        $display("FAIL full_pulse: got h=%0d v=%0d c=%h @%0d want h=%0d v=%0d c=%h @%0d",
                                 ho[2], vo[2], co[2], c, e.h, e.v, e.c, e.t);
                    end
                end
            end
            if (c < 6) begin
                hin = HB'(40 + c); vin_c = VB'(100 - c); sel = 3'(c + 4);
                vld = 1'b1;
                exp_rdy = (c < 5);
                tests++;
                if (rdy[2] !== exp_rdy) begin
                    fails++;
                    $display("FAIL full_ready: got %b want %b at offer %0d", rdy[2], exp_rdy, c);
                end
                if (exp_rdy)
                    sb.push_back('{h: hin, v: vin_c, c: col(hin, vin_c, sel), t: 21 + 20 * c});
            end else begin
                vld = 1'b0;
            end
        end
        tests++;
        if (got != 5 || sb.size() != 0) begin
            fails++;
            $display("FAIL full_count: got %0d pulses want 5", got);
        end
    endtask

    task automatic test_reset_mid();
        int got = 0;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clk_in);
            if (c < 4) begin
                hin = HB'(c + 1); vin_c = VB'(c + 2); sel = 3'd5; vld = 1'b1;
            end else begin
                vld = 1'b0;
            end
        end
        tests++;
        if (bsy[2] !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_busy_pre: got %b want 1", bsy[2]);
        end
        rst_in = 1'b1;
        vld    = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        vld    = 1'b0;
        tests++;
        if ({rdy[2], vout[2], bsy[2]} !== 3'b100 || ho[2] !== '0
            || vo[2] !== '0 || co[2] !== '0) begin
            fails++;
            $display("FAIL rstmid_state: rdy=%b vout=%b busy=%b h=%0d v=%0d c=%h, want 1 0 0 0 0 0",
                     rdy[2], vout[2], bsy[2], ho[2], vo[2], co[2]);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_in);
            if (vout[2]) got++;
        end
        tests++;
        if (got != 0) begin
            fails++;
            $display("FAIL rstmid_pulses: got %0d pulses want 0", got);
        end
    endtask

    task automatic test_lfsr(input int k);
        int   i;
        int   acc = 0;
        int   ret = 0;
        int   last_r = 0;
        int   start;
        int   lat;
        int   c = 0;
        exp_t e;
        i = 3 + k;
        do_reset();
        while (ret < 200 && c < 5000) begin
            if (c > 0) @(negedge clk_in);
            if (vout[i]) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL lfsr%0d_extra: pulse at cycle %0d, none expected", k, c);
                end else begin
                    e = sb.pop_front();
                    start = (e.t > last_r) ? e.t : last_r;
                    lat = c - start;
                    if ({ho[i], vo[i], co[i]} !== {e.h, e.v, e.c}
                        || lat < 1 || lat > 16) begin
                        fails++;
                        $display("FAIL lfsr%0d_job%0d: got h=%0d v=%0d c=%h lat=%0d want h=%0d v=%0d c=%h lat 1..16",
                                 k, ret, ho[i], vo[i], co[i], lat, e.h, e.v, e.c);
                    end
                    lat_seq[k][ret] = lat;
                    last_r = c;
                    ret++;
                end
            end
            if (acc < 200) begin
                hin = HB'(acc); vin_c = VB'(acc * 7); sel = 3'(acc + k);
                vld = 1'b1;
                if (rdy[i] === 1'b1) begin
                    sb.push_back('{h: hin, v: vin_c, c: col(hin, vin_c, sel), t: c + 1});
                    acc++;
                end
            end else begin
                vld = 1'b0;
            end
            c++;
        end
        vld = 1'b0;
        tests++;
        if (ret != 200) begin
            fails++;
            $display("FAIL lfsr%0d_count: got %0d retired want 200", k, ret);
        end
    endtask

    task automatic test_core_diff();
        bit diff = 1'b0;
        for (int j = 0; j < 200; j++)
            if (lat_seq[0][j] != lat_seq[1][j]) diff = 1'b1;
        tests++;
        if (!diff) begin
            fails++;
            $display("FAIL core_diff: got identical latency sequences want differing");
        end
    endtask

    initial begin
        vld = 1'b0; hin = '0; vin_c = '0; sel = '0;
        org = '0; dir = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stream();
        test_full();
        test_reset_mid();
        test_lfsr(0);
        test_lfsr(1);
        test_core_diff();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
